// File: rtl/risc_datapath.sv
// risc_datapath: register-bus CPU datapath with R0-R15, PC, MAR, MDR, Y, Z(64), HI, LO and a combinational ALU.
// Ports: Clock/clear (async active-high reset), Mdatain (memory read data), Read (MDR source select),
//        IncPC, Rin/Rout (register-file load/drive), *in load strobes, *out bus drive strobes, Cout, opcode.
module risc_datapath (
    input  logic        Clock,
    input  logic        clear,
    input  logic [31:0] Mdatain,
    input  logic        Read,
    input  logic        IncPC,
    input  logic [15:0] Rin,
    input  logic [15:0] Rout,
    input  logic        PCin,
    input  logic        Zin,
    input  logic        MDRin,
    input  logic        MARin,
    input  logic        Yin,
    input  logic        HIin,
    input  logic        LOin,
    input  logic        PCout,
    input  logic        Zhighout,
    input  logic        Zlowout,
    input  logic        HIout,
    input  logic        LOout,
    input  logic        MDRout,
    input  logic        Cout,
    input  logic [4:0]  opcode
);
    localparam logic [4:0] OP_ADD = 5'b00011, OP_SUB = 5'b00100, OP_AND = 5'b00101, OP_OR = 5'b00110,
                           OP_SHR = 5'b00111, OP_SHRA = 5'b01000, OP_SHL = 5'b01001, OP_ROR = 5'b01010,
                           OP_ROL = 5'b01011, OP_MUL = 5'b01100, OP_DIV = 5'b01101, OP_NEG = 5'b01110,
                           OP_NOT = 5'b01111;
    localparam logic [31:0] C_CONST = 32'h0;
    logic [31:0] r_q [16];
    logic [31:0] r_d [16];
    logic [31:0] pc_q, pc_d, mar_q, mar_d, mdr_q, mdr_d, y_q, y_d, hi_q, hi_d, lo_q, lo_d;
    logic [63:0] z_q, z_d, alu, ror_t, rol_t;
    logic [31:0] bus;
    logic signed [31:0] quo, rem;
    logic [4:0] sh;
    // Later assignments override earlier ones, so sources are listed lowest priority first.
    always_comb begin
        bus = Cout ? C_CONST : 32'h0;
        if (MDRout) bus = mdr_q;
        if (PCout) bus = pc_q;
        if (Zlowout) bus = z_q[31:0];
        if (Zhighout) bus = z_q[63:32];
        if (LOout) bus = lo_q;
        if (HIout) bus = hi_q;
        for (int i = 15; i >= 0; i--)
            if (Rout[i]) bus = r_q[i];
    end
    // Rotates come from shifting Y concatenated with itself.
    always_comb begin
        sh = bus[4:0];
        ror_t = {y_q, y_q} >> sh;
        rol_t = {y_q, y_q} << sh;
        quo = $signed(y_q) / $signed(bus);
        rem = $signed(y_q) % $signed(bus);
        alu = 64'h0;
        case (opcode)
            OP_ADD:  alu[31:0] = y_q + bus;
            OP_SUB:  alu[31:0] = y_q - bus;
            OP_AND:  alu[31:0] = y_q & bus;
            OP_OR:   alu[31:0] = y_q | bus;
            OP_SHR:  alu[31:0] = y_q >> sh;
            OP_SHRA: alu[31:0] = $signed(y_q) >>> sh;
            OP_SHL:  alu[31:0] = y_q << sh;
            OP_ROR:  alu[31:0] = ror_t[31:0];
            OP_ROL:  alu[31:0] = rol_t[63:32];
            OP_MUL:  alu = {{32{y_q[31]}}, y_q} * {{32{bus[31]}}, bus};
            OP_DIV:  alu = (bus == 32'h0) ? 64'h0 : {rem, quo};
            OP_NEG:  alu[31:0] = -bus;
            OP_NOT:  alu[31:0] = ~bus;
            default: alu = 64'h0;
        endcase
    end
    always_comb begin
        r_d = r_q;
        for (int i = 0; i < 16; i++)
            if (Rin[i]) r_d[i] = bus;
        pc_d = IncPC ? pc_q + 32'd1 : PCin ? bus : pc_q;
        mar_d = MARin ? bus : mar_q;
        mdr_d = MDRin ? (Read ? Mdatain : bus) : mdr_q;
        y_d = Yin ? bus : y_q;
        hi_d = HIin ? bus : hi_q;
        lo_d = LOin ? bus : lo_q;
        z_d = Zin ? alu : z_q;
    end
    always_ff @(posedge Clock or posedge clear) begin
        if (clear) begin
            r_q <= '{default: 32'h0};
            pc_q <= 32'h0;
            mar_q <= 32'h0;
            mdr_q <= 32'h0;
            y_q <= 32'h0;
            hi_q <= 32'h0;
            lo_q <= 32'h0;
            z_q <= 64'h0;
        end else begin
            r_q <= r_d;
            pc_q <= pc_d;
            mar_q <= mar_d;
            mdr_q <= mdr_d;
            y_q <= y_d;
            hi_q <= hi_d;
            lo_q <= lo_d;
            z_q <= z_d;
        end
    end
endmodule

// File: tb/tb_risc_datapath.sv
// tb_risc_datapath: self-checking bench for risc_datapath against a behavioural model.
module tb_risc_datapath;
    logic        Clock = 1'b0;
    logic        clear = 1'b1;
    logic [31:0] Mdatain;
    logic        Read, IncPC, PCin, Zin, MDRin, MARin, Yin, HIin, LOin;
    logic        PCout, Zhighout, Zlowout, HIout, LOout, MDRout, Cout;
    logic [15:0] Rin, Rout;
    logic [4:0]  opcode;
    int vectors = 0;
    int miscompares = 0;
    logic [31:0] m_r [16];

    risc_datapath dut (
        .Clock(Clock), .clear(clear), .Mdatain(Mdatain), .Read(Read), .IncPC(IncPC),
        .Rin(Rin), .Rout(Rout), .PCin(PCin), .Zin(Zin), .MDRin(MDRin), .MARin(MARin),
        .Yin(Yin), .HIin(HIin), .LOin(LOin), .PCout(PCout), .Zhighout(Zhighout),
        .Zlowout(Zlowout), .HIout(HIout), .LOout(LOout), .MDRout(MDRout), .Cout(Cout),
        .opcode(opcode)
    );

    always #5 Clock = ~Clock;

    task automatic idle();
        Mdatain = 32'h0; Read = 0; IncPC = 0; PCin = 0; Zin = 0; MDRin = 0; MARin = 0;
        Yin = 0; HIin = 0; LOin = 0; PCout = 0; Zhighout = 0; Zlowout = 0; HIout = 0;
        LOout = 0; MDRout = 0; Cout = 0; Rin = 16'h0; Rout = 16'h0; opcode = 5'h0;
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic load_mdr(input logic [31:0] v);
        Mdatain = v; Read = 1; MDRin = 1;
        tick();
        idle();
    endtask

    task automatic mdr_to_r(input int i);
        MDRout = 1; Rin = 16'(1) << i;
        tick();
        idle();
    endtask

    task automatic do_alu(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op);
        load_mdr(a);
        MDRout = 1; Yin = 1;
        tick();
        idle();
        load_mdr(b);
        MDRout = 1; Zin = 1; opcode = op;
        tick();
        idle();
    endtask

    function automatic logic [63:0] ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op);
        int unsigned s;
        logic [31:0] t;
        int ia, ib;
        longint p;
        s = b % 32;
        t = a;
        ia = a;
        ib = b;
        case (op)
            5'd3:  return {32'h0, a + b};
            5'd4:  return {32'h0, a - b};
            5'd5:  return {32'h0, a & b};
            5'd6:  return {32'h0, a | b};
            5'd7:  return {32'h0, a >> s};
            5'd8:  return {32'h0, 32'(ia >>> s)};
            5'd9:  return {32'h0, a << s};
            5'd10: begin
                repeat (s) t = {t[0], t[31:1]};
                return {32'h0, t};
            end
            5'd11: begin
                repeat (s) t = {t[30:0], t[31]};
                return {32'h0, t};
            end
            5'd12: begin
                p = longint'(ia) * longint'(ib);
                return 64'(p);
            end
            5'd13: return (ib == 0) ? 64'h0 : {32'(ia % ib), 32'(ia / ib)};
            5'd14: return {32'h0, 32'h0 - b};
            5'd15: return {32'h0, ~b};
            default: return 64'h0;
        endcase
    endfunction

    task automatic test_reset();
        idle();
        repeat (2) tick();
        for (int i = 0; i < 16; i++) begin
            vectors++;
            if (dut.r_q[i] !== 32'h0) begin
                miscompares++;
                $display("FAIL reset_r%0d: got %h expected 0", i, dut.r_q[i]);
            end
        end
        vectors++;
        if ({dut.pc_q, dut.mar_q, dut.mdr_q, dut.y_q, dut.hi_q, dut.lo_q, dut.z_q} !== 256'h0) begin
            miscompares++;
            $display("FAIL reset_regs: pc %h mar %h mdr %h y %h hi %h lo %h z %h expected all 0",
                     dut.pc_q, dut.mar_q, dut.mdr_q, dut.y_q, dut.hi_q, dut.lo_q, dut.z_q);
        end
        clear = 0;
        tick();
    endtask

    task automatic test_register_load();
        logic [31:0] vals [3];
        int dst [3];
        vals = '{32'h12, 32'h14, 32'h18};
        dst = '{4, 5, 0};
        for (int k = 0; k < 3; k++) begin
            load_mdr(vals[k]);
            vectors++;
            if (dut.mdr_q !== vals[k]) begin
                miscompares++;
                $display("FAIL load_mdr: got %h expected %h", dut.mdr_q, vals[k]);
            end
            mdr_to_r(dst[k]);
            vectors++;
            if (dut.r_q[dst[k]] !== vals[k]) begin
                miscompares++;
                $display("FAIL load_r%0d: got %h expected %h", dst[k], dut.r_q[dst[k]], vals[k]);
            end
        end
    endtask

    task automatic test_fetch();
        PCout = 1; MARin = 1; IncPC = 1;
        tick();
        idle();
        vectors++;
        if (dut.mar_q !== 32'h0 || dut.pc_q !== 32'h1) begin
            miscompares++;
            $display("FAIL fetch1: mar %h pc %h expected mar 0 pc 1", dut.mar_q, dut.pc_q);
        end
        PCin = 1; IncPC = 1;
        tick();
        idle();
        vectors++;
        if (dut.pc_q !== 32'h2) begin
            miscompares++;
            $display("FAIL fetch_inc_priority: got %h expected 2", dut.pc_q);
        end
    endtask

    task automatic test_add();
        Rout = 16'h0010; Yin = 1;
        tick();
        idle();
        vectors++;
        if (dut.y_q !== 32'h12) begin
            miscompares++;
            $display("FAIL add_y: got %h expected 12", dut.y_q);
        end
        Rout = 16'h0020; opcode = 5'b00011; Zin = 1;
        tick();
        idle();
        vectors++;
        if (dut.z_q !== 64'h26) begin
            miscompares++;
            $display("FAIL add_z: got %h expected 26", dut.z_q);
        end
        Zlowout = 1; Rin = 16'h0001;
        tick();
        idle();
        vectors++;
        if (dut.r_q[0] !== 32'h26) begin
            miscompares++;
            $display("FAIL add_r0: got %h expected 26", dut.r_q[0]);
        end
    endtask

    task automatic test_arith_corners();
        do_alu(32'hFFFF_FFFF, 32'h2, 5'b01100);
        vectors++;
        if (dut.z_q !== 64'hFFFF_FFFF_FFFF_FFFE) begin
            miscompares++;
            $display("FAIL mul_neg: got %h expected fffffffffffffffe", dut.z_q);
        end
        do_alu(32'h7, 32'h2, 5'b01101);
        vectors++;
        if (dut.z_q !== 64'h0000_0001_0000_0003) begin
            miscompares++;
            $display("FAIL div_7_2: got %h expected 0000000100000003", dut.z_q);
        end
        do_alu(32'h7, 32'h0, 5'b01101);
        vectors++;
        if (dut.z_q !== 64'h0) begin
            miscompares++;
            $display("FAIL div_zero: got %h expected 0", dut.z_q);
        end
        do_alu(32'hFFFF_FFFF, 32'h1, 5'b00011);
        vectors++;
        if (dut.z_q !== 64'h0) begin
            miscompares++;
            $display("FAIL add_wrap: got %h expected 0", dut.z_q);
        end
    endtask

    task automatic test_bus_priority();
        load_mdr(32'h99);
        Rout = 16'h0010; MDRout = 1; Yin = 1;
        tick();
        idle();
        vectors++;
        if (dut.y_q !== 32'h12) begin
            miscompares++;
            $display("FAIL prio_r_over_mdr: got %h expected 12", dut.y_q);
        end
        Yin = 1;
        tick();
        idle();
        vectors++;
        if (dut.y_q !== 32'h0) begin
            miscompares++;
            $display("FAIL prio_none: got %h expected 0", dut.y_q);
        end
        load_mdr(32'h55);
        MDRout = 1; HIin = 1;
        tick();
        idle();
        load_mdr(32'h66);
        MDRout = 1; LOin = 1;
        tick();
        idle();
        HIout = 1; LOout = 1; MDRout = 1; Cout = 1; Yin = 1;
        tick();
        idle();
        vectors++;
        if (dut.y_q !== 32'h55) begin
            miscompares++;
            $display("FAIL prio_hi_over_lo: got %h expected 55", dut.y_q);
        end
        LOout = 1; MDRout = 1; Yin = 1;
        tick();
        idle();
        vectors++;
        if (dut.y_q !== 32'h66) begin
            miscompares++;
            $display("FAIL prio_lo_over_mdr: got %h expected 66", dut.y_q);
        end
        MDRout = 1; Cout = 1; MARin = 1;
        tick();
        idle();
        vectors++;
        if (dut.mar_q !== 32'h66) begin
            miscompares++;
            $display("FAIL prio_mdr_over_cout: got %h expected 66", dut.mar_q);
        end
    endtask

    task automatic test_random_regs();
        int src;
        for (int i = 0; i < 16; i++) begin
            m_r[i] = $urandom;
            load_mdr(m_r[i]);
            mdr_to_r(i);
        end
        for (int n = 0; n < 24; n++) begin
            logic [15:0] ro, ri;
            ro = 16'($urandom_range(1, 65535));
            ri = 16'($urandom);
            src = 0;
            while (!ro[src]) src++;
            Rout = ro; Rin = ri; MDRout = $urandom_range(0, 1) == 1; PCout = 1;
            tick();
            idle();
            for (int i = 0; i < 16; i++)
                if (ri[i]) m_r[i] = m_r[src];
            for (int i = 0; i < 16; i++) begin
                vectors++;
                if (dut.r_q[i] !== m_r[i]) begin
                    miscompares++;
                    $display("FAIL rand_regs n%0d r%0d: got %h expected %h", n, i, dut.r_q[i], m_r[i]);
                end
            end
        end
    endtask

    task automatic test_random_alu();
        logic [4:0] ops [13];
        ops = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15};
        for (int n = 0; n < 80; n++) begin
            logic [31:0] a, b;
            logic [4:0] op;
            logic [63:0] e;
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            if ($urandom_range(0, 7) == 0) b = -b;
            op = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : ops[$urandom_range(0, 12)];
            if (op == 5'd13 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'h1;
            e = ref_alu(a, b, op);
            do_alu(a, b, op);
            vectors++;
            if (dut.z_q !== e) begin
                miscompares++;
                $display("FAIL rand_alu op%0d a %h b %h: got %h expected %h", op, a, b, dut.z_q, e);
            end
            if (n % 2 == 0) begin
                Zhighout = 1; Zlowout = 1;
            end else Zlowout = 1;
            Yin = 1;
            tick();
            idle();
            vectors++;
            if (dut.y_q !== (n % 2 == 0 ? e[63:32] : e[31:0])) begin
                miscompares++;
                $display("FAIL rand_zout n%0d: got %h expected %h", n, dut.y_q, n % 2 == 0 ? e[63:32] : e[31:0]);
            end
        end
    endtask

    task automatic test_clear_midrun();
        load_mdr(32'h12);
        mdr_to_r(4);
        load_mdr(32'h5);
        MDRout = 1; PCin = 1;
        tick();
        idle();
        vectors++;
        if (dut.pc_q !== 32'h5 || dut.r_q[4] !== 32'h12) begin
            miscompares++;
            $display("FAIL clear_setup: pc %h r4 %h expected 5 12", dut.pc_q, dut.r_q[4]);
        end
        #2 clear = 1;
        #1;
        vectors++;
        if (dut.r_q[4] !== 32'h0 || dut.pc_q !== 32'h0 || dut.mdr_q !== 32'h0) begin
            miscompares++;
            $display("FAIL clear_async: r4 %h pc %h mdr %h expected 0", dut.r_q[4], dut.pc_q, dut.mdr_q);
        end
        IncPC = 1; Mdatain = 32'hFF; Read = 1; MDRin = 1; Rin = 16'hFFFF; Cout = 1;
        tick();
        idle();
        vectors++;
        if (dut.pc_q !== 32'h0 || dut.mdr_q !== 32'h0) begin
            miscompares++;
            $display("FAIL clear_priority: pc %h mdr %h expected 0", dut.pc_q, dut.mdr_q);
        end
        clear = 0;
        tick();
    endtask

    initial begin
        idle();
        test_reset();
        test_register_load();
        test_fetch();
        test_add();
        test_arith_corners();
        test_bus_priority();
        test_random_regs();
        test_random_alu();
        test_clear_midrun();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
